// File: rtl/rv_fifo_flex.sv
// Ready/valid FIFO with arbitrary depth, synchronous flush, programmable
// almost-full/almost-empty flags, sticky overflow and optional output register.
module rv_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int OUT_REG       = 0,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CAP          = FIFO_DEPTH + OUT_REG,
    localparam int CW           = $clog2(CAP + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [CW-1:0]         data_count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CAP_C = CW'(CAP);
    localparam logic [CW-1:0] AF_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C  = CW'(AEMPTY_THRESH);

    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("rv_fifo_flex: FIFO_DEPTH must be at least 2");
    end
    if (AFULL_THRESH > CAP) begin : g_chk_afull
        $error("rv_fifo_flex: AFULL_THRESH exceeds capacity");
    end
    if (AEMPTY_THRESH > CAP) begin : g_chk_aempty
        $error("rv_fifo_flex: AEMPTY_THRESH exceeds capacity");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         arr_cnt_q, arr_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  in_xact, out_xact;
    logic                  arr_wr, arr_rd;
    logic                  oreg_vld;
    logic [DATA_WIDTH-1:0] head_data;

    // Explicit wrap so non-power-of-two depths use every entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign data_count   = arr_cnt_q + {{(CW-1){1'b0}}, oreg_vld};
    assign empty        = (data_count == '0);
    assign full         = (data_count == CAP_C);
    assign almost_full  = (data_count >= AF_C);
    assign almost_empty = (data_count <= AE_C);
    assign overflow     = ovf_q;

    assign in_rdy    = !full && !flush;
    assign out_val   = !empty && !flush;
    assign in_xact   = in_val && in_rdy;
    assign out_xact  = out_val && out_rdy;
    assign head_data = mem[rd_ptr_q];

    if (OUT_REG != 0) begin : g_oreg
        logic                  oreg_vld_q, oreg_vld_d;
        logic [DATA_WIDTH-1:0] oreg_q, oreg_d;
        logic                  slot;

        // The register refills from the array first; the bypass path is only
        // taken when the array is empty so ordering stays strictly FIFO.
        always_comb begin
            slot       = !oreg_vld_q || out_xact;
            arr_rd     = slot && (arr_cnt_q != '0);
            arr_wr     = in_xact && !(slot && (arr_cnt_q == '0));
            oreg_vld_d = oreg_vld_q;
            oreg_d     = oreg_q;
            if (flush) begin
                oreg_vld_d = 1'b0;
            end else if (slot) begin
                if (arr_cnt_q != '0) begin
                    oreg_vld_d = 1'b1;
                    oreg_d     = head_data;
                end else if (in_xact) begin
                    oreg_vld_d = 1'b1;
                    oreg_d     = in_data;
                end else begin
                    oreg_vld_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                oreg_vld_q <= 1'b0;
                oreg_q     <= '0;
            end else begin
                oreg_vld_q <= oreg_vld_d;
                oreg_q     <= oreg_d;
            end
        end

        assign oreg_vld = oreg_vld_q;
        assign out_data = oreg_q;
    end else begin : g_comb_out
        assign arr_wr   = in_xact;
        assign arr_rd   = out_xact;
        assign oreg_vld = 1'b0;
        assign out_data = head_data;
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        arr_cnt_d = arr_cnt_q;
        ovf_d     = ovf_q;
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            arr_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (arr_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (arr_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({arr_wr, arr_rd})
                2'b10:   arr_cnt_d = arr_cnt_q + 1'b1;
                2'b01:   arr_cnt_d = arr_cnt_q - 1'b1;
                default: arr_cnt_d = arr_cnt_q;
            endcase
            ovf_d = ovf_q || (in_val && full);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            arr_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            arr_cnt_q <= arr_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is data only: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (arr_wr) mem[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_rv_fifo_flex.sv
// Drives a combinational-output (depth 5) and a registered-output (depth 4)
// FIFO, both capacity 5, with identical stimulus against one queue model.
module tb_rv_fifo_flex;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_val = 1'b0;
    logic       out_rdy = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       a_in_rdy, a_out_val, a_empty, a_full, a_af, a_ae, a_ovf;
    logic [7:0] a_out_data;
    logic [2:0] a_cnt;
    logic       b_in_rdy, b_out_val, b_empty, b_full, b_af, b_ae, b_ovf;
    logic [7:0] b_out_data;
    logic [2:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .OUT_REG(0),
                   .AFULL_THRESH(3), .AEMPTY_THRESH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_val(in_val), .in_rdy(a_in_rdy),
        .out_data(a_out_data), .out_val(a_out_val), .out_rdy(out_rdy),
        .data_count(a_cnt), .empty(a_empty), .full(a_full),
        .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf)
    );

    rv_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .OUT_REG(1),
                   .AFULL_THRESH(3), .AEMPTY_THRESH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_val(in_val), .in_rdy(b_in_rdy),
        .out_data(b_out_data), .out_val(b_out_val), .out_rdy(out_rdy),
        .data_count(b_cnt), .empty(b_empty), .full(b_full),
        .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf)
    );

    // Reference model: a plain queue of accepted payloads plus the sticky flag.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    int         e_cnt;
    logic       e_full, e_empty, e_ir, e_ov;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input logic ir, input logic ov,
                           input logic [7:0] od, input logic [2:0] dc,
                           input logic e, input logic f, input logic af,
                           input logic ae, input logic ovf);
        chk({tag, ".in_rdy"}, int'(ir), int'(e_ir));
        chk({tag, ".out_val"}, int'(ov), int'(e_ov));
        chk({tag, ".data_count"}, int'(dc), e_cnt);
        chk({tag, ".empty"}, int'(e), int'(e_empty));
        chk({tag, ".full"}, int'(f), int'(e_full));
        chk({tag, ".almost_full"}, int'(af), int'(e_cnt >= 3));
        chk({tag, ".almost_empty"}, int'(ae), int'(e_cnt <= 2));
        chk({tag, ".overflow"}, int'(ovf), int'(m_ovf));
        if (ov && e_ov) chk({tag, ".out_data"}, int'(od), int'(q[0]));
    endtask

    // Monitor/scoreboard: sampled on the falling edge, then the model
    // advances to the state the next rising edge should produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end
        e_cnt   = q.size();
        e_full  = (e_cnt == 5);
        e_empty = (e_cnt == 0);
        e_ir    = !e_full && !flush;
        e_ov    = !e_empty && !flush;
        chk_dut("A", a_in_rdy, a_out_val, a_out_data, a_cnt, a_empty, a_full, a_af, a_ae, a_ovf);
        chk_dut("B", b_in_rdy, b_out_val, b_out_data, b_cnt, b_empty, b_full, b_af, b_ae, b_ovf);
        if (!rst_n) chk("B.out_data_reset", int'(b_out_data), 0);
        if (rst_n) begin
            if (e_ov && out_rdy) void'(q.pop_front());
            if (e_ir && in_val) q.push_back(in_data);
            if (flush) begin
                q.delete();
                m_ovf = 1'b0;
            end else if (in_val && e_full) begin
                m_ovf = 1'b1;
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_val  = v;
        in_data = d;
        out_rdy = r;
        flush   = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // Fill to capacity, then overflow attempts with 0xAA.
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
        cyc(0, 8'h00, 0, 0);
        repeat (3) cyc(1, 8'hAA, 0, 0);
        cyc(0, 8'h00, 0, 0);

        // Drain in order, wrapping the read pointer.
        repeat (7) cyc(0, 8'h00, 1, 0);

        // Streaming across several pointer wraps.
        for (int i = 0; i < 50; i++) cyc(1, 8'(8'h40 + i), 1, 0);
        repeat (3) cyc(0, 8'h00, 1, 0);

        // Flush with three entries held, then a fresh push.
        cyc(1, 8'h21, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h23, 0, 0);
        cyc(1, 8'h99, 1, 1);
        cyc(1, 8'h33, 1, 0);
        repeat (3) cyc(0, 8'h00, 1, 0);

        // Asynchronous reset in mid-cycle with three entries held.
        cyc(1, 8'h51, 0, 0);
        cyc(1, 8'h52, 0, 0);
        cyc(1, 8'h53, 0, 0);
        in_val  = 1'b0;
        out_rdy = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 8'h77, 0, 0);
        cyc(0, 8'h00, 0, 0);
        repeat (2) cyc(0, 8'h00, 1, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 4) == 0), 8'($urandom),
                1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (8) cyc(0, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
